mean_unpack: RTL and testbench
==============================

# mean_unpack

Inverse of the datapath's pair-mean block: takes the stream that block emits (a 16-bit mean, optionally negated, plus a sign flag) together with the operand difference, and reconstructs the original signed operand pair A/B exactly. It is a three-stage pipeline with a valid/ready handshake on both sides. It sits on the decode side of the pair-compression path, downstream of the link that carries mean/difference words.

## Interface
Parameters:
- W, default 16: operand and mean width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- ivalid  in  1  input word valid.
- iready  out  1  input accepted when ivalid & iready.
- sign  in  1  M arrived negated (two's complement, W-bit wrap).
- M  in  W  signed mean as delivered.
- D  in  W+1  signed difference A−B.
- ovalid  out  1  output pair valid.
- oready  in  1  downstream accepts when ovalid & oready.
- A  out  W  reconstructed signed operand A.
- B  out  W  reconstructed signed operand B.
- ovf  out  1  reconstruction exceeded W bits (inconsistent input); qualified by ovalid.

## Operation
- Stage 1, de-sign: m = sign ? −M : M, computed in W bits with wrap, so M = −2^(W−1) with sign=1 yields m = −2^(W−1). This matches the producer's wrap.
- Stage 2, sum rebuild: S = 2·m + D[0], in W+2 bits. A+B and A−B share parity, so D[0] restores the bit dropped by the arithmetic shift.
- Stage 3, split: a = (S + D) >>> 1 and b = (S − D) >>> 1, in W+2 bits. ovf = 1 if either value is outside the signed W range.
- Each stage is a register slot holding a valid bit and data. A slot loads when it is empty or its contents move downstream in the same cycle.
  - iready = !v1 | (v1 & adv1), which chains through to oready (combinational ripple is permitted).
- No state machine beyond the three valid bits. Item order is preserved and items are never dropped or duplicated.
- Simultaneous accept and emit on a full pipeline: both happen, and occupancy is unchanged.

## Timing
- Latency: 3 cycles from an accepted input to ovalid, with oready held high.
- Throughput: 1 word per cycle when oready is continuously high.
- While reset is low at a clock edge, all valid bits clear, and A, B and ovf clear to 0.
  - ovalid = 0 and iready = 0 during reset.
  - iready = 1 on the first cycle after reset deasserts.
- Reset mid-operation discards every in-flight item, and no partial output appears.
- Under backpressure (ovalid & !oready), A, B and ovf hold stable until accepted.
- Maximum occupancy is 3 items. With oready low, iready drops once all three slots are full.

## Configuration
- MEAN_UNPACK_SAT_EN defined: on overflow, A and B saturate to the signed W limits (+2^(W−1)−1 or −2^(W−1)), and ovf = 1.
- MEAN_UNPACK_SAT_EN undefined: A and B are the low W bits of a and b (wrap), and ovf still reports the overflow.

## Structure
- Shared package mean_pkg holds:
  - the constants MEAN_W = 16 and DIFF_W = MEAN_W+1;
  - a packed typedef for the stage payload (m/S, D, ovf).
- One sub-module, mean_unpack_slot: a parameterised single register slot with valid/ready and a data-width parameter. It is instantiated three times, and the arithmetic sits between the slots in the parent.

## Test plan
- Nominal case: sign=0, M=1, D=7, oready=1 → ovalid exactly 3 cycles later with A=5, B=−2, ovf=0. Repeating with sign=1, M=−1 gives the same result.
- Extremes:
  - M=32767, D=0 → A=B=32767.
  - sign=1, M=−32768, D=0 → A=B=−32768.
  - M=−1, D=65535 → A=32767, B=−32768.
  - All of these give ovf=0.
- Inconsistent input: M=32767, D=−65535 → ovf=1.
  - With MEAN_UNPACK_SAT_EN: A=0, B=32767.
  - Without it: A=0, B=−1.
- Backpressure: stream 10 words with ivalid held high, and hold oready low for 4 cycles mid-stream.
  - iready falls once 3 items are held.
  - Outputs stay stable while stalled.
  - All 10 pairs arrive in order with none lost.
- Reset mid-flight: apply reset low for 1 cycle with 3 items in the pipe → next cycle ovalid=0 and A=B=0. Inputs fed after reset are the only ones that emerge.
- Random: 10k random A/B pairs are passed through a reference model of the mean block (with random sign) and then this block → output equals the original pair, with ovf=0 throughout, under random oready toggling.

Source files
------------

// File: rtl/mean_pkg.sv
// Shared widths and stage payloads for the pair-mean decode path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mean_pkg;

  localparam int MEAN_W = 16;
  localparam int DIFF_W = MEAN_W + 1;
  // Sum/split arithmetic needs two guard bits above the mean width.
  localparam int SUM_W  = MEAN_W + 2;

  // Payload carried by the first two slots: de-signed mean (later the
  // rebuilt sum), the difference, and an overflow flag riding along.
  typedef struct packed {
    logic signed [SUM_W-1:0]  ms;
    logic signed [DIFF_W-1:0] d;
    logic                     ovf;
  } stage_t;

  // Payload of the output slot: reconstructed pair plus overflow.
  typedef struct packed {
    logic [MEAN_W-1:0] a;
    logic [MEAN_W-1:0] b;
    logic              ovf;
  } out_t;

  // True when the three bits at and above the W-bit sign position agree,
  // i.e. the W+2 bit value fits the signed W-bit range.
  function automatic logic fits_w(input logic [SUM_W-MEAN_W:0] hi);
    return (&hi) | ~(|hi);
  endfunction

endpackage

// File: rtl/mean_unpack_slot.sv
// Single pipeline register slot: valid bit plus DW-bit payload.
// Latency: 1 cycle from accept to out_vld_o.
// Backpressure: in_rdy_o = empty or draining this cycle (ripples from out_rdy_i).
module mean_unpack_slot #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_vld_i,
  output logic          in_rdy_o,
  input  logic [DW-1:0] in_dat_i,
  output logic          out_vld_o,
  input  logic          out_rdy_i,
  output logic [DW-1:0] out_dat_o
);

  logic          vld_q, vld_d;
  logic [DW-1:0] dat_q, dat_d;
  logic          load;

  assign in_rdy_o  = !vld_q | out_rdy_i;
  assign load      = in_vld_i & in_rdy_o;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

  // Next state: load new data, drain on downstream accept, else hold.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (load) begin
      vld_d = 1'b1;
      dat_d = in_dat_i;
    end else if (out_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  // Slot register with synchronous active-low clear of valid and data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/mean_unpack.sv
// Rebuilds signed pair A/B from (sign, mean M, difference D); optional
// saturation on overflow via MEAN_UNPACK_SAT_EN. Latency: 3 cycles.
// Backpressure: valid/ready both sides; iready ripples back from oready.
module mean_unpack
  import mean_pkg::*;
#(
  // Payload types are sized by MEAN_W; W must stay equal to it.
  parameter int W = MEAN_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ivalid,
  output logic                iready,
  input  logic                sign,
  input  logic signed [W-1:0] M,
  input  logic signed [W:0]   D,
  output logic                ovalid,
  input  logic                oready,
  output logic signed [W-1:0] A,
  output logic signed [W-1:0] B,
  output logic                ovf
);

  stage_t s1_d, s1_q, s2_d, s2_q;
  out_t   s3_d, s3_q;
  logic   v1, v2, v3;
  logic   rdy1, rdy2, rdy3;

  logic signed [W-1:0]   m_w;
  logic signed [W+1:0]   d_ext, sum_a, sum_b, a_full, b_full;
  logic                  a_fit, b_fit;

  // Stage 1: undo the optional negation, wrapping in W bits exactly as
  // the producer did (so -(-2^(W-1)) stays -2^(W-1)).
  always_comb begin
    m_w     = sign ? -M : M;
    s1_d.ms = {{2{m_w[W-1]}}, m_w};
    s1_d.d  = D;
    s1_d.ovf = 1'b0;
  end

  // Stage 2: A+B = 2m + lsb(D), since A+B and A-B have equal parity.
  always_comb begin
    s2_d.ms  = s1_q.ms + s1_q.ms + {{(W+1){1'b0}}, s1_q.d[0]};
    s2_d.d   = s1_q.d;
    s2_d.ovf = s1_q.ovf;
  end

  // Stage 3: split the sum with the difference and range-check.
  always_comb begin
    d_ext    = {s2_q.d[W], s2_q.d};
    sum_a    = s2_q.ms + d_ext;
    sum_b    = s2_q.ms - d_ext;
    a_full   = sum_a >>> 1;
    b_full   = sum_b >>> 1;
    a_fit    = fits_w(a_full[W+1:W-1]);
    b_fit    = fits_w(b_full[W+1:W-1]);
    s3_d.ovf = s2_q.ovf | !a_fit | !b_fit;
`ifdef MEAN_UNPACK_SAT_EN
    s3_d.a   = a_fit ? a_full[W-1:0] : (a_full[W+1] ? {1'b1, {(W-1){1'b0}}}
                                                    : {1'b0, {(W-1){1'b1}}});
    s3_d.b   = b_fit ? b_full[W-1:0] : (b_full[W+1] ? {1'b1, {(W-1){1'b0}}}
                                                    : {1'b0, {(W-1){1'b1}}});
`else
    s3_d.a   = a_full[W-1:0];
    s3_d.b   = b_full[W-1:0];
`endif
  end

  mean_unpack_slot #(.DW($bits(stage_t))) u_slot1 (
    .clock(clock), .reset(reset),
    .in_vld_i(ivalid & reset), .in_rdy_o(rdy1), .in_dat_i(s1_d),
    .out_vld_o(v1), .out_rdy_i(rdy2), .out_dat_o(s1_q)
  );

  mean_unpack_slot #(.DW($bits(stage_t))) u_slot2 (
    .clock(clock), .reset(reset),
    .in_vld_i(v1), .in_rdy_o(rdy2), .in_dat_i(s2_d),
    .out_vld_o(v2), .out_rdy_i(rdy3), .out_dat_o(s2_q)
  );

  mean_unpack_slot #(.DW($bits(out_t))) u_slot3 (
    .clock(clock), .reset(reset),
    .in_vld_i(v2), .in_rdy_o(rdy3), .in_dat_i(s3_d),
    .out_vld_o(v3), .out_rdy_i(oready), .out_dat_o(s3_q)
  );

  // Handshakes are held off while reset is asserted.
  assign iready = rdy1 & reset;
  assign ovalid = v3 & reset;
  assign A      = s3_q.a;
  assign B      = s3_q.b;
  assign ovf    = s3_q.ovf;

endmodule

// File: tb/tb_mean_unpack.sv
// Scoreboard bench for mean_unpack: random pairs through a mean-block model.
// Latency: checks 3-cycle latency on directed items.
// Backpressure: scripted stalls and random oready toggling.
module tb_mean_unpack;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               ivalid = 1'b0;
  logic               sign = 1'b0;
  logic               oready = 1'b0;
  logic signed [15:0] M = '0;
  logic signed [16:0] D = '0;
  logic               iready, ovalid, ovf;
  logic signed [15:0] A, B;

  always #5 clock = ~clock;

  mean_unpack #(.W(16)) dut (
    .clock(clock), .reset(reset),
    .ivalid(ivalid), .iready(iready),
    .sign(sign), .M(M), .D(D),
    .ovalid(ovalid), .oready(oready),
    .A(A), .B(B), .ovf(ovf)
  );

  typedef struct {
    int a;
    int b;
    bit ovf;
    int cyc;
    bit lat;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0, cyc = 0, n_acc = 0, n_out = 0;
  int   exp_a = 0, exp_b = 0;
  bit   exp_ovf = 1'b0, exp_lat = 1'b0;
  int   omode = 0;  // 0: oready high, 1: random, 2: oready low
  bit   prev_stall = 1'b0;
  int   pa = 0, pb = 0, po = 0;

`ifdef MEAN_UNPACK_SAT_EN
  localparam int INC_B = 32767;
`else
  localparam int INC_B = -1;
`endif

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #3;
    case (omode)
      0:       oready = 1'b1;
      1:       oready = ($urandom_range(0, 9) < 7);
      default: oready = 1'b0;
    endcase
  end

  // Monitor: pops expected pairs on output handshakes, pushes on input ones.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_ovalid", int'(ovalid), 1);
        chk("hold_A", int'(A), pa);
        chk("hold_B", int'(B), pb);
        chk("hold_ovf", int'(ovf), po);
      end
      if (ovalid && oready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got A=%0d B=%0d, expected no output", A, B);
        end else begin
          e = q.pop_front();
          chk("out_A", int'(A), e.a);
          chk("out_B", int'(B), e.b);
          chk("out_ovf", int'(ovf), int'(e.ovf));
          if (e.lat) chk("latency", cyc - e.cyc, 3);
          n_out++;
        end
      end
      prev_stall = ovalid && !oready;
      pa = int'(A);
      pb = int'(B);
      po = int'(ovf);
      if (ivalid && iready) begin
        q.push_back('{a: exp_a, b: exp_b, ovf: exp_ovf, cyc: cyc, lat: exp_lat});
        n_acc++;
      end
    end
  end

  // Present one word and hold it until accepted (bounded).
  task automatic send(input bit s, input int m, input int d,
                      input int ea, input int eb, input bit eo, input bit lat);
    int n;
    bit hs;
    sign    = s;
    M       = 16'(m);
    D       = 17'(d);
    exp_a   = ea;
    exp_b   = eb;
    exp_ovf = eo;
    exp_lat = lat;
    ivalid  = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      hs = ivalid && iready;
      @(posedge clock);
      #1;
      if (hs) break;
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept in 500 cycles, expected accept");
        break;
      end
    end
    ivalid = 1'b0;
  endtask

  // Reference mean block: D = A-B, mean = floor((A+B)/2), optional negation.
  task automatic send_pair(input int a, input int b, input bit s);
    int mean;
    mean = (a + b) >>> 1;
    send(s, s ? -mean : mean, a - b, a, b, 1'b0, 1'b0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
    end
  endtask

  int base;

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ovalid", int'(ovalid), 0);
    chk("rst_iready", int'(iready), 0);
    chk("rst_A", int'(A), 0);
    chk("rst_B", int'(B), 0);
    chk("rst_ovf", int'(ovf), 0);
    reset = 1'b1;
    #1;
    chk("iready_after_rst", int'(iready), 1);

    // Directed cases with latency check
    send(1'b0, 1, 7, 5, -2, 1'b0, 1'b1);
    send(1'b1, -1, 7, 5, -2, 1'b0, 1'b1);
    send(1'b0, 32767, 0, 32767, 32767, 1'b0, 1'b1);
    send(1'b1, -32768, 0, -32768, -32768, 1'b0, 1'b1);
    send(1'b0, -1, 65535, 32767, -32768, 1'b0, 1'b1);
    send(1'b0, 32767, -65535, 0, INC_B, 1'b1, 1'b1);
    wait_drain();
    chk("directed_count", n_out, 6);

    // Backpressure: 10 words streamed, 4-cycle stall mid-stream
    base = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send_pair($urandom_range(0, 65535) - 32768,
                    $urandom_range(0, 65535) - 32768, 1'($urandom_range(0, 1)));
      end
      begin
        int n;
        int acc0;
        acc0 = n_acc;
        n = 0;
        while (n_acc < acc0 + 5 && n < 500) begin
          @(posedge clock);
          n++;
        end
        #1;
        omode = 2;
        for (int k = 0; k < 4; k++) begin
          @(negedge clock);
          chk("stall_ovalid", int'(ovalid), 1);
          if (k >= 1) chk("stall_iready", int'(iready), 0);
        end
        @(posedge clock);
        #1;
        omode = 0;
      end
    join
    wait_drain();
    chk("bp_count", n_out - base, 10);

    // Reset with three items in flight
    @(posedge clock);
    #1;
    omode = 2;
    for (int i = 0; i < 3; i++)
      send_pair($urandom_range(0, 65535) - 32768,
                $urandom_range(0, 65535) - 32768, 1'b0);
    chk("full_before_rst", int'(ovalid), 1);
    reset = 1'b0;
    #1;
    chk("midrst_iready", int'(iready), 0);
    chk("midrst_ovalid", int'(ovalid), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("postrst_ovalid", int'(ovalid), 0);
    chk("postrst_A", int'(A), 0);
    chk("postrst_B", int'(B), 0);
    omode = 0;
    base = n_out;
    send_pair(100, -200, 1'b1);
    send_pair(-7, 3, 1'b0);
    send_pair(32767, -32768, 1'b1);
    wait_drain();
    chk("postrst_count", n_out - base, 3);

    // Random pairs under random oready
    omode = 1;
    base = n_out;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clock);
        #1;
      end
      send_pair($urandom_range(0, 65535) - 32768,
                $urandom_range(0, 65535) - 32768, 1'($urandom_range(0, 1)));
    end
    omode = 0;
    wait_drain();
    chk("random_count", n_out - base, 10000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
